// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if #(
    parameter int PC_W   = 12,
    parameter int INST_W = 16
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order requests to instruction memory,
// a small response buffer feeding the IF/ID register, stall hold and redirect flush.
module fetch_unit #(
    parameter int                PC_W     = 12,
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [PC_W-1:0]   RESET_PC = 12'h000,
    parameter logic [INST_W-1:0] NOP      = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallF,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    fetch_unit_if.master      bus,
    output logic [PC_W-1:0]   pcF,
    output logic [INST_W-1:0] instF,
    output logic              validF
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  outstanding_next;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PC_W-1:0]   pc_buf   [DEPTH];
    logic [INST_W-1:0] inst_buf [DEPTH];

    logic credit;
    logic req;
    logic handshake;
    logic resp;
    logic drop;
    logic push;
    logic pop;

    // Requests in flight plus buffered words never exceed DEPTH, so a push always has room.
    assign credit    = ({1'b0, outstanding} + {1'b0, count}) < (CNT_W + 1)'(DEPTH);
    assign req       = reset && !redirect_valid && credit;
    assign handshake = req && bus.imem_ready;
    assign resp      = bus.imem_rvalid && (outstanding != '0);
    assign drop      = discard != '0;
    assign push      = resp && !drop && !redirect_valid;
    assign pop       = validF && !stallF && !redirect_valid;

    assign outstanding_next = outstanding + CNT_W'(handshake) - CNT_W'(resp);

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;

    assign validF = count != '0;
    assign pcF    = validF ? pc_buf[rd_ptr]   : resp_pc;
    assign instF  = validF ? inst_buf[rd_ptr] : NOP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight belongs to the abandoned path.
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                discard  <= outstanding_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (handshake) fetch_pc <= fetch_pc + PC_W'(1);
                if (resp && drop) discard <= discard - CNT_W'(1);
                if (push) begin
                    resp_pc <= resp_pc + PC_W'(1);
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[wr_ptr]   <= resp_pc;
            inst_buf[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with variable latency
// and an expected-PC-sequence reference model.
module tb_fetch_unit;
    localparam int          PC_W     = 12;
    localparam int          INST_W   = 16;
    localparam int          DEPTH    = 2;
    localparam logic [11:0] RESET_PC = 12'h000;
    localparam logic [15:0] NOP      = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stallF = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic [11:0] pcF;
    logic [15:0] instF;
    logic        validF;

    fetch_unit_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

    fetch_unit #(
        .PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)
    ) dut (
        .clk(clk), .reset(reset), .stallF(stallF), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .bus(bus), .pcF(pcF), .instF(instF), .validF(validF)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] addr; int due; } rsp_t;
    typedef struct {
        logic st; logic rdy; logic req; logic [11:0] addr; logic vld; logic [11:0] pc;
    } vec_t;

    rsp_t        q[$];
    logic [11:0] popped[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          npop = 0;
    logic        rst_drive = 1'b0;
    logic [11:0] exp_pc = RESET_PC;
    logic [11:0] exp_req = RESET_PC;
    logic        hold = 1'b0;
    logic [11:0] hold_pc = '0;
    logic [15:0] hold_inst = '0;
    logic        pend = 1'b0;
    logic [11:0] pend_addr = '0;

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        return {a[3:0] ^ 4'h9, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_init();
        q.delete();
        popped.delete();
        exp_pc   = RESET_PC;
        exp_req  = RESET_PC;
        hold     = 1'b0;
        pend     = 1'b0;
        last_due = cyc;
    endtask

    // One cycle: drive at negedge, sample 1 time unit later, update the model.
    task automatic step(input logic st, input logic rv, input logic [11:0] rpc, input logic rdy);
        int inflight;
        int due;
        @(negedge clk);
        reset              = rst_drive;
        stallF             = st;
        redirect_valid     = rv;
        redirect_pc        = rpc;
        bus.imem_ready     = rdy;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 16'($urandom);
        inflight           = q.size();
        if (q.size() > 0 && q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(q[0].addr);
            q.delete(0);
        end
        #1;
        if (!reset) begin
            chk("rst_req", 32'(bus.imem_req), 32'(1'b0));
            chk("rst_valid", 32'(validF), 32'(1'b0));
            chk("rst_pc", 32'(pcF), 32'(RESET_PC));
            chk("rst_inst", 32'(instF), 32'(NOP));
        end else begin
            chk("credit", 32'(inflight <= DEPTH), 32'(1'b1));
            if (pend && !rv) begin
                chk("addr_hold_req", 32'(bus.imem_req), 32'(1'b1));
                chk("addr_hold", 32'(bus.imem_addr), 32'(pend_addr));
            end
            if (rv) chk("redir_req", 32'(bus.imem_req), 32'(1'b0));
            if (bus.imem_req) chk("req_addr", 32'(bus.imem_addr), 32'(exp_req));
            if (hold) begin
                chk("stall_valid", 32'(validF), 32'(1'b1));
                chk("stall_pc", 32'(pcF), 32'(hold_pc));
                chk("stall_inst", 32'(instF), 32'(hold_inst));
            end
            if (validF) begin
                chk("pc_seq", 32'(pcF), 32'(exp_pc));
                chk("inst_data", 32'(instF), 32'(mem_word(pcF)));
            end
            if (bus.imem_req && rdy) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                q.push_back('{addr: bus.imem_addr, due: due});
                exp_req++;
            end
            pend      = bus.imem_req && !rdy;
            pend_addr = bus.imem_addr;
            hold      = validF && st && !rv;
            hold_pc   = pcF;
            hold_inst = instF;
            if (rv) begin
                exp_pc  = rpc;
                exp_req = rpc;
            end else if (validF && !st) begin
                popped.push_back(pcF);
                npop++;
                exp_pc++;
            end
        end
        cyc++;
    endtask

    initial begin
        vec_t        tbl[9];
        logic [11:0] wrap_seq[4];
        logic        seen;

        // 1-cycle memory, always ready: credit of 2 gives a three-cycle rhythm.
        tbl[0] = '{st:0, rdy:1, req:1, addr:12'h000, vld:0, pc:12'h000};
        tbl[1] = '{st:0, rdy:1, req:1, addr:12'h001, vld:0, pc:12'h000};
        tbl[2] = '{st:0, rdy:1, req:0, addr:12'h002, vld:1, pc:12'h000};
        tbl[3] = '{st:0, rdy:1, req:1, addr:12'h002, vld:1, pc:12'h001};
        tbl[4] = '{st:0, rdy:1, req:1, addr:12'h003, vld:0, pc:12'h002};
        tbl[5] = '{st:0, rdy:1, req:0, addr:12'h004, vld:1, pc:12'h002};
        tbl[6] = '{st:0, rdy:1, req:1, addr:12'h004, vld:1, pc:12'h003};
        tbl[7] = '{st:0, rdy:1, req:1, addr:12'h005, vld:0, pc:12'h004};
        tbl[8] = '{st:0, rdy:1, req:0, addr:12'h006, vld:1, pc:12'h004};
        wrap_seq[0] = 12'hFFE; wrap_seq[1] = 12'hFFF; wrap_seq[2] = 12'h000; wrap_seq[3] = 12'h001;

        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        rst_drive = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
        model_init();
        rst_drive = 1'b1;

        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].st, 1'b0, 12'h000, tbl[i].rdy);
            chk($sformatf("tbl%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_valid", i), 32'(validF), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_pc", i), 32'(pcF), 32'(tbl[i].pc));
        end

        // Stall: output frozen, requests stop once credit is used up.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'h000, 1'b1);
        chk("stall_req_drop", 32'(bus.imem_req), 32'(1'b0));
        chk("stall_full_valid", 32'(validF), 32'(1'b1));
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 12'h000, 1'b1);

        // Redirect with two stale requests in flight.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 12'h000, 1'b1);
            if (q.size() >= 2) break;
        end
        chk("t3_outstanding", 32'(q.size()), 32'(2));
        step(1'b0, 1'b1, 12'h0A0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b0, 1'b0, 12'h000, 1'b1);
            if (validF) begin
                seen = 1'b1;
                chk("t3_first_pc", 32'(pcF), 32'(12'h0A0));
                chk("t3_first_inst", 32'(instF), 32'(mem_word(12'h0A0)));
            end
        end
        chk("t3_seen", 32'(seen), 32'(1'b1));

        // Address wrap.
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b1, 12'hFFE, 1'b1);
        popped.delete();
        for (int i = 0; i < 40 && popped.size() < 4; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("t4_count", 32'(popped.size() >= 4), 32'(1'b1));
        if (popped.size() >= 4)
            for (int i = 0; i < 4; i++) chk($sformatf("t4_wrap%0d", i), 32'(popped[i]), 32'(wrap_seq[i]));

        // Random ready, latency, stall and redirects.
        lat_min = 1; lat_max = 4;
        npop = 0;
        for (int i = 0; i < 600; i++)
            step(($urandom % 4) == 0, ($urandom % 25) == 0, 12'($urandom), 1'($urandom));
        chk("t5_progress", 32'(npop > 20), 32'(1'b1));

        // Reset mid-stream with responses arriving while reset is low.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 12'h000, 1'b1);
            if (q.size() >= 2) break;
        end
        rst_drive = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'h000, 1'b1);
        model_init();
        rst_drive = 1'b1;
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("t6_req", 32'(bus.imem_req), 32'(1'b1));
        chk("t6_addr", 32'(bus.imem_addr), 32'(RESET_PC));
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b0, 1'b0, 12'h000, 1'b1);
            if (validF) begin
                seen = 1'b1;
                chk("t6_first_pc", 32'(pcF), 32'(RESET_PC));
                chk("t6_first_inst", 32'(instF), 32'(mem_word(RESET_PC)));
            end
        end
        chk("t6_seen", 32'(seen), 32'(1'b1));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 12'h000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
